// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period_meter block.
package period_meter_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } pm_state_e;

endpackage

// File: rtl/pm_edge_detect.sv
// Edge detector for the measured signal; define PERIOD_METER_SYNC_EN to insert
// a two-flop synchronizer ahead of the edge register.
module pm_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], sig_i};
    end

    assign s_o = sync_q[1];
`else
    // Source is already in the clk domain, so it feeds the edge register directly.
    assign s_o = sig_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= s_o;
    end

    assign rise_o = s_o & ~prev_q;
    assign fall_o = ~s_o & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a divided clock in source-clock cycles.
// Build option: PERIOD_METER_SYNC_EN (see pm_edge_detect).
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_ARM  = CNT_W'(TIMEOUT - 1);

    pm_state_e        state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             hdone_q, hdone_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             timeout_q, timeout_d;

    logic s, rise, fall;

    pm_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sig_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            per_q       <= '0;
            high_q      <= '0;
            hdone_q     <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            per_q       <= per_d;
            high_q      <= high_d;
            hdone_q     <= hdone_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        per_d       = per_q;
        high_d      = high_q;
        hdone_d     = hdone_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    wait_d  = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = MEASURE;
                    per_d   = CNT_ONE;
                    high_d  = CNT_ONE;
                    hdone_d = 1'b0;
                end else if (wait_q >= TO_ARM) begin
                    state_d     = HOLD;
                    timeout_d   = 1'b1;
                    period_d    = '0;
                    high_time_d = '0;
                end else begin
                    wait_d = wait_q + CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    state_d     = HOLD;
                    period_d    = per_q;
                    high_time_d = high_q;
                    timeout_d   = 1'b0;
                end else if (per_q >= TO_LIM) begin
                    // Period would exceed TIMEOUT: abort instead of counting on.
                    state_d     = HOLD;
                    timeout_d   = 1'b1;
                    period_d    = '0;
                    high_time_d = '0;
                end else begin
                    if (per_q != CNT_MAX) per_d = per_q + CNT_ONE;
                    // Only the first high phase after the rise is counted.
                    if (fall)
                        hdone_d = 1'b1;
                    else if (s && !hdone_q && high_q != CNT_MAX)
                        high_d = high_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (meas_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign meas_valid = (state_q == HOLD);
    assign period     = period_q;
    assign high_time  = high_time_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: vector table plus hold/reset/back-to-back sequences.
module tb_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b0;
    logic             start = 1'b0;
    logic             meas_ready = 1'b0;
    logic             busy, meas_valid, timeout;
    logic [CNT_W-1:0] period, high_time;

    int errors = 0;
    int checks = 0;

    // Source generator: gen_div==0 holds gen_level, else gen_hi high out of gen_div cycles.
    int   gen_div = 4;
    int   gen_hi  = 2;
    logic gen_level = 1'b0;
    int   gen_ph  = 0;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .start      (start),
        .busy       (busy),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .period     (period),
        .high_time  (high_time),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gen_div == 0) begin
            sig_in = gen_level;
        end else begin
            gen_ph = (gen_ph + 1) % gen_div;
            sig_in = (gen_ph < gen_hi);
        end
    end

    typedef struct {
        string name;
        int    div;
        int    hi;
        logic  level;
        int    exp_per;
        int    exp_high;
        int    exp_to;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_src(input int div, input int hi, input logic level);
        gen_div   = div;
        gen_hi    = hi;
        gen_level = level;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_result(input string nm, input int ep, input int eh, input int eto);
        int n;
        n = 0;
        while (!meas_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " meas_valid"}, int'(meas_valid), 1);
        chk({nm, " period"}, int'(period), ep);
        chk({nm, " high_time"}, int'(high_time), eh);
        chk({nm, " timeout"}, int'(timeout), eto);
        chk({nm, " busy in hold"}, int'(busy), 1);
    endtask

    task automatic measure(input string nm, input int ep, input int eh, input int eto);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy after start"}, int'(busy), 1);
        wait_result(nm, ep, eh, eto);
    endtask

    task automatic handshake(input string nm, input int ep);
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        chk({nm, " valid after ack"}, int'(meas_valid), 0);
        chk({nm, " busy after ack"}, int'(busy), 0);
        chk({nm, " period retained"}, int'(period), ep);
    endtask

    initial begin
        int   n;
        int   vcount;
        logic last;

        vecs[0] = '{"div4",   4,  2, 1'b0,  4,  2, 0};
        vecs[1] = '{"div5",   5,  2, 1'b0,  5,  2, 0};
        vecs[2] = '{"div15", 15,  7, 1'b0, 15,  7, 0};
        vecs[3] = '{"div3",   3,  1, 1'b0,  3,  1, 0};
        vecs[4] = '{"div2",   2,  1, 1'b0,  2,  1, 0};
        vecs[5] = '{"div20", 20, 10, 1'b0, 20, 10, 0};
        vecs[6] = '{"div21", 21, 10, 1'b0,  0,  0, 1};
        vecs[7] = '{"const1", 0,  0, 1'b1,  0,  0, 1};
        vecs[8] = '{"const0", 0,  0, 1'b0,  0,  0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset meas_valid", int'(meas_valid), 0);
        chk("reset timeout", int'(timeout), 0);
        chk("reset period", int'(period), 0);
        chk("reset high_time", int'(high_time), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            set_src(vecs[i].div, vecs[i].hi, vecs[i].level);
            measure(vecs[i].name, vecs[i].exp_per, vecs[i].exp_high, vecs[i].exp_to);
            handshake(vecs[i].name, vecs[i].exp_per);
        end

        // Held result: outputs frozen, start ignored while meas_ready low
        set_src(4, 2, 1'b0);
        measure("hold", 4, 2, 0);
        for (int c = 0; c < 10; c++) begin
            start = (c == 5);
            @(negedge clk);
            chk("hold frozen", int'({meas_valid, busy, timeout, period, high_time}),
                int'({1'b1, 1'b1, 1'b0, 8'd4, 8'd2}));
        end
        // Start coincident with the handshake must be dropped
        meas_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        start      = 1'b0;
        chk("hold ack valid", int'(meas_valid), 0);
        chk("hold ack busy", int'(busy), 0);
        @(negedge clk);
        chk("start in ack ignored", int'(busy), 0);

        // Reset while in MEASURE
        set_src(4, 2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last = sig_in;
        n = 0;
        while (!(sig_in && !last) && n < 50) begin
            last = sig_in;
            @(negedge clk);
            n++;
        end
        chk("rise seen before reset", int'(n < 50), 1);
        @(negedge clk);
        @(negedge clk);
        chk("busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset outputs", int'({busy, meas_valid, timeout, period, high_time}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (meas_valid || busy) vcount++;
        end
        chk("no activity after reset", vcount, 0);
        measure("post reset", 4, 2, 0);

        // Back-to-back: start on the first IDLE cycle after the handshake
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        start      = 1'b1;
        chk("b2b idle", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b accepted", int'(busy), 1);
        wait_result("b2b", 4, 2, 0);
        handshake("b2b", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
